// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for one dat_mem arbiter port.
// The requester drives master; the arbiter takes slave.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdat;

    modport master (output req, we, addr, wdat, input gnt, rvalid, rdat);
    modport slave  (input req, we, addr, wdat, output gnt, rvalid, rdat);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single dat_mem port, with bursts
// bounded to HOLD_MAX transactions while the other port waits.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave p0,
    dmem_arbiter_if.slave p1,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
);
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t        owner;
    owner_t        owner_nxt;
    logic          last_p1;     // 1 when port 1 was the most recent owner
    logic [CW-1:0] cnt;
    logic          txn0;
    logic          txn1;
    logic          hold_done;

    // Grants come straight off the owner register so an async reset kills them at once.
    assign p0.gnt    = (owner == OWN_P0);
    assign p1.gnt    = (owner == OWN_P1);
    assign txn0      = p0.gnt && p0.req;
    assign txn1      = p1.gnt && p1.req;
    assign hold_done = (cnt == CNT_TOP);

    assign mem_addr   = (owner == OWN_P1) ? p1.addr : p0.addr;
    assign mem_dat_in = (owner == OWN_P1) ? p1.wdat : p0.wdat;
    assign mem_wr_en  = (txn0 && p0.we) || (txn1 && p1.we);

    always_comb begin
        // NOTE: default assignment first keeps every path covered, so no latch is inferred.
        owner_nxt = owner;
        case (owner)
            OWN_NONE: begin
                if (p0.req && p1.req) owner_nxt = last_p1 ? OWN_P0 : OWN_P1;
                else if (p0.req)      owner_nxt = OWN_P0;
                else if (p1.req)      owner_nxt = OWN_P1;
                else                  owner_nxt = OWN_NONE;
            end
            OWN_P0: begin
                if (!p0.req)                   owner_nxt = p1.req ? OWN_P1 : OWN_NONE;
                else if (p1.req && hold_done)  owner_nxt = OWN_P1;
                else                           owner_nxt = OWN_P0;
            end
            OWN_P1: begin
                if (!p1.req)                   owner_nxt = p0.req ? OWN_P0 : OWN_NONE;
                else if (p0.req && hold_done)  owner_nxt = OWN_P0;
                else                           owner_nxt = OWN_P1;
            end
            default: owner_nxt = OWN_NONE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= OWN_NONE;
            last_p1   <= 1'b1;
            cnt       <= '0;
            p0.rvalid <= 1'b0;
            p1.rvalid <= 1'b0;
            p0.rdat   <= '0;
            p1.rdat   <= '0;
        end else begin
            owner <= owner_nxt;
            if (owner_nxt != owner) begin
                cnt <= '0;
                if (owner != OWN_NONE) last_p1 <= (owner == OWN_P1);
            end else if ((txn0 || txn1) && !hold_done) begin
                cnt <= cnt + 1'b1;
            end

            p0.rvalid <= txn0 && !p0.we;
            p1.rvalid <= txn1 && !p1.we;
            if (txn0 && !p0.we) p0.rdat <= mem_dat_out;
            if (txn1 && !p1.we) p1.rdat <= mem_dat_out;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle table for the main flows plus
// hand-written sequences for tie, starvation, reset and random exclusivity.
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       mem_wr_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_dat_in;
    logic [7:0] mem_dat_out;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter_if #(.AW(8), .DW(8)) if0 ();
    dmem_arbiter_if #(.AW(8), .DW(8)) if1 ();

    dmem_arbiter #(.AW(8), .DW(8), .HOLD_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .p0         (if0.slave),
        .p1         (if1.slave),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat_in (mem_dat_in),
        .mem_dat_out(mem_dat_out)
    );

    always #5 clk = ~clk;

    // dat_mem model: combinational read, write on the rising edge.
    assign mem_dat_out = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

    typedef struct {
        logic       r0, w0; logic [7:0] a0, d0;
        logic       r1, w1; logic [7:0] a1, d1;
        logic       g0, g1, wr; logic [7:0] ma, din;
        logic       rv0, rv1; logic [7:0] rd0, rd1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r0, w0, input logic [7:0] a0, d0,
                       input logic r1, w1, input logic [7:0] a1, d1,
                       input logic g0, g1, wr, input logic [7:0] ma, din,
                       input logic rv0, rv1, input logic [7:0] rd0, rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.wr = wr; v.ma = ma; v.din = din;
        v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r0, w0, input logic [7:0] a0, d0,
                         input logic r1, w1, input logic [7:0] a1, d1);
        if0.req = r0; if0.we = w0; if0.addr = a0; if0.wdat = d0;
        if1.req = r1; if1.we = w1; if1.addr = a1; if1.wdat = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gnt1_at;
        int p0_txn;

        for (int i = 0; i < 256; i++) mem[i] = ~8'(i);

        //    r0 w0 a0     d0     r1 w1 a1     d1     | g0 g1 wr ma     din    rv0 rv1 rd0    rd1
        add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00,   0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        add(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00,   0, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        add(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00,   1, 0, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        add(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00,   1, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        add(0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00,   1, 0, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 8'h00);
        add(0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00,   0, 0, 0, 8'h10, 8'h00, 0, 0, 8'hA5, 8'h00);
        add(1, 0, 8'h10, 8'h00, 1, 0, 8'h03, 8'h00,   0, 0, 0, 8'h10, 8'h00, 0, 0, 8'hA5, 8'h00);
        add(1, 0, 8'h10, 8'h00, 1, 0, 8'h03, 8'h00,   0, 1, 0, 8'h03, 8'h00, 0, 0, 8'hA5, 8'h00);
        add(1, 0, 8'h10, 8'h00, 0, 0, 8'h03, 8'h00,   0, 1, 0, 8'h03, 8'h00, 0, 1, 8'hA5, 8'hFC);
        add(1, 0, 8'h10, 8'h00, 0, 0, 8'h03, 8'h00,   1, 0, 0, 8'h10, 8'h00, 0, 0, 8'hA5, 8'hFC);
        add(0, 0, 8'h10, 8'h00, 0, 0, 8'h03, 8'h00,   1, 0, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 8'hFC);
        add(0, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'h33,   0, 0, 0, 8'h20, 8'h00, 0, 0, 8'hA5, 8'hFC);
        add(1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 8'h33,   0, 1, 1, 8'h20, 8'h33, 0, 0, 8'hA5, 8'hFC);
        add(1, 0, 8'h20, 8'h00, 0, 0, 8'h20, 8'h00,   0, 1, 0, 8'h20, 8'h00, 0, 0, 8'hA5, 8'hFC);
        add(1, 0, 8'h20, 8'h00, 0, 0, 8'h20, 8'h00,   1, 0, 0, 8'h20, 8'h00, 0, 0, 8'hA5, 8'hFC);
        add(0, 0, 8'h20, 8'h00, 0, 0, 8'h20, 8'h00,   1, 0, 0, 8'h20, 8'h00, 1, 0, 8'h33, 8'hFC);
        add(0, 0, 8'h20, 8'h00, 0, 0, 8'h20, 8'h00,   0, 0, 0, 8'h20, 8'h00, 0, 0, 8'h33, 8'hFC);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            check($sformatf("v%0d gnt0", i),      if0.gnt,    vecs[i].g0);
            check($sformatf("v%0d gnt1", i),      if1.gnt,    vecs[i].g1);
            check($sformatf("v%0d mem_wr_en", i), mem_wr_en,  vecs[i].wr);
            check($sformatf("v%0d mem_addr", i),  mem_addr,   vecs[i].ma);
            check($sformatf("v%0d rvalid0", i),   if0.rvalid, vecs[i].rv0);
            check($sformatf("v%0d rvalid1", i),   if1.rvalid, vecs[i].rv1);
            check($sformatf("v%0d rdat0", i),     if0.rdat,   vecs[i].rd0);
            check($sformatf("v%0d rdat1", i),     if1.rdat,   vecs[i].rd1);
            if (vecs[i].wr) check($sformatf("v%0d mem_dat_in", i), mem_dat_in, vecs[i].din);
            step();
        end

        // Tie out of reset: P0 first, read latency 2, handover straight to P1.
        do_reset();
        drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
        @(negedge clk);
        check("tie c0 gnt0", if0.gnt, 1'b0);
        check("tie c0 gnt1", if1.gnt, 1'b0);
        step();
        @(negedge clk);
        check("tie c1 gnt0", if0.gnt, 1'b1);
        check("tie c1 gnt1", if1.gnt, 1'b0);
        step();
        @(negedge clk);
        check("tie c2 rvalid0", if0.rvalid, 1'b1);
        check("tie c2 rdat0", if0.rdat, 8'hFE);
        step();
        if0.req = 1'b0;
        @(negedge clk);
        check("tie c3 gnt0", if0.gnt, 1'b1);
        check("tie c3 mem_wr_en", mem_wr_en, 1'b0);
        step();
        @(negedge clk);
        check("tie c4 gnt0", if0.gnt, 1'b0);
        check("tie c4 gnt1", if1.gnt, 1'b1);
        check("tie c4 mem_addr", mem_addr, 8'h02);
        step();
        if1.req = 1'b0;
        @(negedge clk);
        check("tie c5 rvalid1", if1.rvalid, 1'b1);
        check("tie c5 rdat1", if1.rdat, 8'hFD);
        step();

        // Starvation bound: P0 streams reads, P1 joins at cycle 2.
        do_reset();
        gnt1_at = -1;
        p0_txn  = 0;
        for (int c = 0; c < 14; c++) begin
            if0.req  = (c < 10);
            if0.we   = 1'b0;
            if0.addr = 8'(c);
            if1.req  = (c >= 2) && (gnt1_at < 0);
            if1.we   = 1'b0;
            if1.addr = 8'h30;
            @(negedge clk);
            check($sformatf("starve c%0d exclusive", c), if0.gnt && if1.gnt, 1'b0);
            if (if0.gnt && if0.req && gnt1_at < 0) p0_txn++;
            if (if1.gnt && gnt1_at < 0) begin
                gnt1_at = c;
                check("starve p1 mem_addr", mem_addr, 8'h30);
            end
            step();
        end
        check("starve p0 txns before p1", p0_txn, 4);
        check("starve gnt1 cycle", gnt1_at, 5);
        check("starve wait within bound", (gnt1_at >= 2) && (gnt1_at - 2 <= 5), 1'b1);

        // Reset mid-burst: read then write back-to-back, reset lands inside the write cycle.
        do_reset();
        drive(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
        step();
        step();
        drive(1, 1, 8'h40, 8'h77, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        check("rst pre gnt0", if0.gnt, 1'b1);
        check("rst pre mem_wr_en", mem_wr_en, 1'b1);
        check("rst pre rvalid0", if0.rvalid, 1'b1);
        check("rst pre rdat0", if0.rdat, 8'hFA);
        #2 reset = 1'b1;
        #1;
        check("rst gnt0", if0.gnt, 1'b0);
        check("rst gnt1", if1.gnt, 1'b0);
        check("rst mem_wr_en", mem_wr_en, 1'b0);
        check("rst rvalid0", if0.rvalid, 1'b0);
        check("rst rdat0", if0.rdat, 8'h00);
        step();
        check("rst no partial write", mem[8'h40], 8'hBF);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        reset = 1'b0;

        // Random traffic: grants stay mutually exclusive, writes only under a grant.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)));
            @(negedge clk);
            check($sformatf("rand c%0d exclusive", c), if0.gnt && if1.gnt, 1'b0);
            check($sformatf("rand c%0d wr_en gated", c),
                  mem_wr_en && !((if0.gnt && if0.req && if0.we) || (if1.gnt && if1.req && if1.we)), 1'b0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
